// File: rtl/jailbreak_audio_i2s_pkg.sv
// Shared constants for the Jailbreak audio path: sample width, frame/bit timing
// and the width of the frame-average accumulator.
package jailbreak_audio_i2s_pkg;

  localparam int SOUND_W        = 16;
  localparam int WORD_W         = 32;
  localparam int FRAME_LOG2_DEF = 10;
  localparam int BIT_LOG2_DEF   = 4;
  localparam int FRAME_LEN      = 1 << FRAME_LOG2_DEF;
  localparam int BIT_PERIOD     = 1 << BIT_LOG2_DEF;

  localparam logic signed [SOUND_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SOUND_W-1:0] SAT_MIN = 16'sh8000;

  // A full frame of worst-case samples needs FRAME_LOG2 extra bits of headroom.
  function automatic int acc_width(input int frame_log2);
    return SOUND_W + frame_log2;
  endfunction

  localparam int ACC_W = acc_width(FRAME_LOG2_DEF);

endpackage

// File: rtl/jailbreak_audio_i2s_sat_gain.sv
// Combinational volume stage: left-shift a signed sample by 0..3 and clamp the
// result to the 16-bit signed range.
module audio_sat_gain
  import jailbreak_audio_i2s_pkg::*;
(
  input  logic signed [SOUND_W-1:0] i_sample,
  input  logic        [1:0]         i_gain,
  output logic signed [SOUND_W-1:0] o_sample
);

  logic signed [SOUND_W+2:0] w_wide;

  assign w_wide = $signed({{3{i_sample[SOUND_W-1]}}, i_sample}) <<< i_gain;

  always_comb begin
    o_sample = w_wide[SOUND_W-1:0];
    if (w_wide > (SOUND_W+3)'(SAT_MAX)) begin
      o_sample = SAT_MAX;
    end else if (w_wide < (SOUND_W+3)'(SAT_MIN)) begin
      o_sample = SAT_MIN;
    end
  end

endmodule

// File: rtl/jailbreak_audio_i2s.sv
// I2S transmitter for the Jailbreak core: averages the free-running PCM over each
// frame and shifts the scaled mean out on both channels during the following frame.
module jailbreak_audio_i2s
  import jailbreak_audio_i2s_pkg::*;
#(
  parameter int FRAME_LOG2 = FRAME_LOG2_DEF,
  parameter int BIT_LOG2   = BIT_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [SOUND_W-1:0] sound,
  input  logic        [1:0]         gain,
  input  logic                      mute,
  output logic                      sample_strobe,
  output logic                      audio_mclk,
  output logic                      audio_lrck,
  output logic                      audio_dac
);

  localparam int W_ACC = acc_width(FRAME_LOG2);

  logic        [FRAME_LOG2-1:0] r_count;
  logic signed [W_ACC-1:0]      r_acc;
  logic        [WORD_W-1:0]     r_shift;
  logic                         r_strobe;

  logic                         w_load;
  logic                         w_rotate;
  logic signed [W_ACC-1:0]      w_sum;
  logic signed [SOUND_W-1:0]    w_avg;
  logic signed [SOUND_W-1:0]    w_scaled;

  assign w_load   = &r_count;
  assign w_rotate = &r_count[BIT_LOG2-1:0];
  // The current sample is folded in so the average covers exactly one frame.
  assign w_sum    = r_acc + W_ACC'(sound);
  assign w_avg    = SOUND_W'(w_sum >>> FRAME_LOG2);

  audio_sat_gain u_sat_gain (
    .i_sample (w_avg),
    .i_gain   (gain),
    .o_sample (w_scaled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_shift  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_count  <= r_count + 1'b1;
      r_strobe <= w_load;
      if (w_load) begin
        r_acc   <= '0;
        // Leading zero gives the I2S one-bit delay after each lrck edge.
        r_shift <= mute ? '0 : {1'b0, w_scaled, {(WORD_W-SOUND_W-1){1'b0}}};
      end else begin
        r_acc <= w_sum;
        if (w_rotate) begin
          r_shift <= {r_shift[WORD_W-2:0], r_shift[WORD_W-1]};
        end
      end
    end
  end

  assign sample_strobe = r_strobe;
  assign audio_mclk    = r_count[1];
  assign audio_lrck    = r_count[FRAME_LOG2-1];
  assign audio_dac     = r_shift[WORD_W-1];

endmodule

// File: doc/jailbreak_audio_i2s.md
JAILBREAK_AUDIO_I2S -- requirements
Module: jailbreak_audio_i2s

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: FRAME_LOG2, default 10, log2 of core clocks per stereo frame (1024 clocks, 48 kHz at 49.152 MHz).
REQ-003 Parameter: BIT_LOG2, default 4, log2 of core clocks per serial bit (16 clocks; 32 bits per half frame).
REQ-004 Port: clk, input, 1, core clock (clk_49_152mhz domain).
REQ-005 Port: reset, input, 1, synchronous active-high reset.
REQ-006 Port: sound, input, 16 signed, free-running PCM from the Jailbreak core, sampled every clock.
REQ-007 Port: gain, input, 2, left-shift volume 0..3, sampled at frame load only.
REQ-008 Port: mute, input, 1, forces the loaded word to zero, sampled at frame load only.
REQ-009 Port: sample_strobe, output, 1, single-cycle pulse on each frame load.
REQ-010 Port: audio_mclk, output, 1, DAC master clock.
REQ-011 Port: audio_lrck, output, 1, left/right word clock (0 = left).
REQ-012 Port: audio_dac, output, 1, serial data, MSB first.

Function
REQ-013 SHALL hold a FRAME_LOG2-bit counter that increments every clock and wraps from 1023 to 0.
REQ-014 audio_lrck SHALL equal counter[9], and audio_mclk SHALL equal counter[1], both registered.
REQ-015 SHALL accumulate the sign-extended sound into a 26-bit signed accumulator every clock.
REQ-016 At counter==1023, the frame average SHALL be (acc + sound) arithmetic-shifted right by 10, i.e. the mean of exactly 1024 samples.
REQ-017 At counter==1023, the accumulator SHALL be cleared so that the next frame starts at counter==0.
REQ-018 The scaled sample SHALL be the average shifted left by gain, saturated to 16-bit signed (+32767 / -32768).
REQ-019 At counter==1023, a 32-bit shifter SHALL load {1'b0, scaled, 15'b0}, or all zeros when mute=1.
REQ-020 The shifter SHALL rotate left by one when counter[3:0]==15 and not load.
REQ-021 Load SHALL take priority over rotate when both apply.
REQ-022 audio_dac SHALL equal shifter[31].
REQ-023 The same word SHALL therefore be sent on both left and right half frames.
REQ-024 sample_strobe SHALL be 1 in the cycle after load (counter==0), and 0 otherwise.
REQ-025 Latency SHALL be one frame: the average of frame N is output during frame N+1, with its first data bit at counter==16 (I2S one-bit delay).
REQ-026 A change of gain or mute mid-frame SHALL NOT affect the word currently being shifted.

Reset
REQ-027 Reset SHALL set counter, accumulator and shifter to 0.
REQ-028 During and immediately after reset, audio_mclk, audio_lrck, audio_dac and sample_strobe SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial accumulation.
REQ-030 After reset releases, the first load SHALL occur 1024 clocks later and SHALL average only post-reset samples.

Structure
REQ-031 Constants for frame length, bit period and accumulator width SHALL live in the shared jailbreak package.
REQ-032 Saturating shift SHALL be a sub-module, audio_sat_gain: 16-bit signed in, 2-bit gain in, 16-bit signed out, purely combinational.
REQ-033 The block SHALL replace the inline serializer in the core top level, and its outputs SHALL drive audio.mclk, audio.lrck and audio.dac.

Verification
REQ-034 Constant sound=16'h1000, gain=0, mute=0 -> after the second load, the shifter holds 32'h08000000, audio_dac is high only for bits 4..4 of each half frame, and sample_strobe has a period of 1024.
REQ-035 Constant sound=16'h1000, gain=3 -> 16'h8000 saturates to 16'h7FFF, and the shifter holds 32'h3FFF8000.
REQ-036 Constant sound=16'h8000, gain=1 -> result is -32768, and the shifter holds 32'h40000000.
REQ-037 sound alternating +100/-100 each clock -> average 0, and audio_dac stays 0.
REQ-038 mute=1 with sound=16'h7FFF -> audio_dac stays 0; toggling mute at counter==500 leaves the current word unchanged.
REQ-039 reset pulse at counter==600 -> next cycle counter=0 and all outputs 0; first sample_strobe arrives 1025 clocks after release, carrying the post-reset average.
